io_bus_responder: RTL and testbench

Memory-mapped I/O responder on the processor's word bus (`mem_addr` / `mem_rstrb` / `mem_rdata`, extended with `mem_wdata` / `mem_wmask`). It sits beside the RAM in the SOC. It answers processor reads and writes to the I/O page, driving the 4 LEDs and an 8N1 UART transmitter on `TXD`. It replaces the constant `TXD = 0` and the direct `x1`-to-LED hookup.

---
 rtl/io_pkg.sv | 17 +
 rtl/uart_tx_core.sv | 79 +++++++
 rtl/io_bus_responder.sv | 93 +++++++++
 tb/tb_io_bus_responder.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/io_pkg.sv
// io_pkg: shared constants for the I/O page responder.
// Holds register offsets, the UART busy bit index and UART state codes.
package io_pkg;

    localparam logic [2:0] IO_LEDS      = 3'd0;
    localparam logic [2:0] IO_UART_DAT  = 3'd1;
    localparam logic [2:0] IO_UART_CNTL = 3'd2;
    localparam logic [2:0] IO_CYCLES    = 3'd3;

    localparam int IO_BUSY_BIT = 9;

    localparam logic [1:0] UART_IDLE  = 2'd0;
    localparam logic [1:0] UART_START = 2'd1;
    localparam logic [1:0] UART_DATA  = 2'd2;
    localparam logic [1:0] UART_STOP  = 2'd3;

endpackage

// File: rtl/uart_tx_core.sv
// uart_tx_core: 8N1 transmitter with registered, glitch-free txd.
// Ports: clk, resetn (async low), start, data[7:0], busy, txd (idle 1).
module uart_tx_core
    import io_pkg::*;
#(
    parameter int CLKS_PER_BIT = 104
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       start,
    input  logic [7:0] data,
    output logic       busy,
    output logic       txd
);

    localparam logic [15:0] BAUD_RELOAD = 16'(CLKS_PER_BIT - 1);

    logic [1:0]  state;
    logic [15:0] baud;
    logic [2:0]  idx;
    logic [7:0]  shreg;

    assign busy = (state != UART_IDLE);

    // Every state/bit lasts exactly CLKS_PER_BIT cycles: the counter is
    // reloaded on entry and the transition happens on the edge it reads 0.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= UART_IDLE;
            baud  <= '0;
            idx   <= '0;
            shreg <= '0;
            txd   <= 1'b1;
        end else begin
            case (state)
                UART_IDLE: begin
                    if (start) begin
                        state <= UART_START;
                        baud  <= BAUD_RELOAD;
                        shreg <= data;
                        txd   <= 1'b0;
                    end
                end
                UART_START: begin
                    if (baud == 16'd0) begin
                        state <= UART_DATA;
                        baud  <= BAUD_RELOAD;
                        idx   <= 3'd0;
                        txd   <= shreg[0];
                    end else begin
                        baud <= baud - 16'd1;
                    end
                end
                UART_DATA: begin
                    if (baud == 16'd0) begin
                        baud <= BAUD_RELOAD;
                        if (idx == 3'd7) begin
                            state <= UART_STOP;
                            txd   <= 1'b1;
                        end else begin
                            idx <= idx + 3'd1;
                            txd <= shreg[idx + 3'd1];
                        end
                    end else begin
                        baud <= baud - 16'd1;
                    end
                end
                default: begin
                    if (baud == 16'd0) begin
                        state <= UART_IDLE;
                    end else begin
                        baud <= baud - 16'd1;
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/io_bus_responder.sv
// io_bus_responder: I/O page on the word bus (LEDs, UART TX, cycle count).
// Ports: clk, resetn, mem_addr/rstrb/wdata/wmask in; io_rdata, leds, txd,
// tx_busy out. Define IO_CYCLE_COUNTER_EN to build the cycle counter.
module io_bus_responder
    import io_pkg::*;
#(
    parameter int CLKS_PER_BIT = 104,
    parameter int IO_PAGE_BIT  = 22
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] mem_addr,
    input  logic        mem_rstrb,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wmask,
    output logic [31:0] io_rdata,
    output logic [3:0]  leds,
    output logic        txd,
    output logic        tx_busy
);

    logic        sel;
    logic [2:0]  off;
    logic        wr;
    logic        tx_start;
    logic [31:0] rd_mux;
    logic [31:0] cycles_rd;
    logic        unused_ok;

    assign sel = mem_addr[IO_PAGE_BIT];
    assign off = mem_addr[4:2];
    assign wr  = sel && (mem_wmask != 4'd0);

    // Writes while busy are dropped; busy is the pre-edge value.
    assign tx_start = wr && mem_wmask[0] && (off == IO_UART_DAT) && !tx_busy;

    assign unused_ok = ^{mem_addr, mem_wdata, mem_wmask};

    uart_tx_core #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx (
        .clk   (clk),
        .resetn(resetn),
        .start (tx_start),
        .data  (mem_wdata[7:0]),
        .busy  (tx_busy),
        .txd   (txd)
    );

`ifdef IO_CYCLE_COUNTER_EN
    logic [31:0] cycles;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cycles <= '0;
        end else begin
            cycles <= cycles + 32'd1;
        end
    end

    assign cycles_rd = cycles;
`else
    assign cycles_rd = '0;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            leds <= '0;
        end else if (wr && mem_wmask[0] && (off == IO_LEDS)) begin
            leds <= mem_wdata[3:0];
        end
    end

    always_comb begin
        rd_mux = '0;
        case (off)
            IO_LEDS:      rd_mux[3:0] = leds;
            IO_UART_CNTL: rd_mux[IO_BUSY_BIT] = tx_busy;
            IO_CYCLES:    rd_mux = cycles_rd;
            default:      rd_mux = '0;
        endcase
    end

    // Sampled from pre-edge state, so a same-edge write is not visible.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            io_rdata <= '0;
        end else if (sel && mem_rstrb) begin
            io_rdata <= rd_mux;
        end
    end

endmodule

// File: tb/tb_io_bus_responder.sv
// tb_io_bus_responder: scoreboard bench for io_bus_responder.
// Reads and UART frames are checked by monitors against queued expectations.
module tb_io_bus_responder;

    logic        clk;
    logic        resetn;
    logic [31:0] mem_addr;
    logic        mem_rstrb;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic [31:0] io_rdata;
    logic [3:0]  leds;
    logic        txd;
    logic        tx_busy;

    int checks;
    int failures;

    typedef struct {
        logic [31:0] v;
        bit          chk;
    } rd_exp_t;

    rd_exp_t    rd_q[$];
    logic [7:0] frame_q[$];

    io_bus_responder #(
        .CLKS_PER_BIT(4),
        .IO_PAGE_BIT (22)
    ) dut (
        .clk      (clk),
        .resetn   (resetn),
        .mem_addr (mem_addr),
        .mem_rstrb(mem_rstrb),
        .mem_wdata(mem_wdata),
        .mem_wmask(mem_wmask),
        .io_rdata (io_rdata),
        .leds     (leds),
        .txd      (txd),
        .tx_busy  (tx_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic bus(input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] m, input logic r);
        @(negedge clk);
        mem_addr  = a;
        mem_wdata = d;
        mem_wmask = m;
        mem_rstrb = r;
        @(posedge clk);
        #1;
        mem_wmask = 4'd0;
        mem_rstrb = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] e);
        rd_q.push_back('{v: e, chk: 1'b1});
        bus(a, 32'd0, 4'd0, 1'b1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Read monitor: every selected read yields one response a cycle later.
    initial begin
        rd_exp_t e;
        forever begin
            @(posedge clk);
            if (resetn && mem_rstrb && mem_addr[22]) begin
                #1;
                if (rd_q.size() == 0) begin
                    chk("rd_unexpected", io_rdata, 32'hxxxxxxxx);
                end else begin
                    e = rd_q.pop_front();
                    if (e.chk) chk("rd_data", io_rdata, e.v);
                end
            end
        end
    end

    // UART monitor: finds the start bit, samples mid-bit (4 clks per bit).
    initial begin
        int         ph;
        bit         active;
        logic [7:0] sh;
        active = 1'b0;
        ph = 0;
        sh = '0;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                active = 1'b0;
            end else if (!active) begin
                if (txd == 1'b0) begin
                    active = 1'b1;
                    ph = 0;
                end
            end else begin
                ph++;
                if (ph == 2) begin
                    chk("uart_start_bit", {31'd0, txd}, 32'd0);
                end else if (ph >= 6 && ph <= 34 && (ph % 4) == 2) begin
                    sh = {txd, sh[7:1]};
                end else if (ph == 38) begin
                    chk("uart_stop_bit", {31'd0, txd}, 32'd1);
                    if (frame_q.size() == 0) begin
                        chk("uart_unexpected", {24'd0, sh}, 32'hxxxxxxxx);
                    end else begin
                        chk("uart_byte", {24'd0, sh}, {24'd0, frame_q.pop_front()});
                    end
                    active = 1'b0;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] c1;
        logic [31:0] c2;
        checks    = 0;
        failures  = 0;
        resetn    = 1'b0;
        mem_addr  = '0;
        mem_rstrb = 1'b0;
        mem_wdata = '0;
        mem_wmask = '0;
        #23;
        chk("rst_leds", {28'd0, leds}, 32'd0);
        chk("rst_txd", {31'd0, txd}, 32'd1);
        chk("rst_busy", {31'd0, tx_busy}, 32'd0);
        chk("rst_rdata", io_rdata, 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        idle(2);
        rd(32'h0040_0008, 32'h0000_0000);

        bus(32'h0040_0000, 32'h5, 4'b0001, 1'b0);
        chk("leds_wr5", {28'd0, leds}, 32'h5);
        rd(32'h0040_0000, 32'h5);

        rd_q.push_back('{v: 32'h5, chk: 1'b1});
        bus(32'h0040_0000, 32'hA, 4'b0001, 1'b1);
        chk("leds_wrA", {28'd0, leds}, 32'hA);
        rd(32'h0040_0000, 32'hA);

        bus(32'h0000_0000, 32'h3, 4'b1111, 1'b0);
        chk("unsel_wr", {28'd0, leds}, 32'hA);
        bus(32'h0000_0008, 32'h0, 4'b0000, 1'b1);
        chk("unsel_rd_hold", io_rdata, 32'hA);
        bus(32'h0040_0010, 32'h7, 4'b0001, 1'b0);
        chk("resv_wr", {28'd0, leds}, 32'hA);
        rd(32'h0040_0010, 32'h0);
        rd(32'h0040_0004, 32'h0);
        bus(32'h0040_0000, 32'h6, 4'b1110, 1'b0);
        chk("leds_mask", {28'd0, leds}, 32'hA);

        frame_q.push_back(8'h41);
        bus(32'h0040_0004, 32'h41, 4'b0001, 1'b0);
        chk("tx_go_busy", {31'd0, tx_busy}, 32'd1);
        chk("tx_go_txd", {31'd0, txd}, 32'd0);
        rd(32'h0040_0008, 32'h200);
        bus(32'h0040_0004, 32'h42, 4'b0001, 1'b0);
        idle(37);
        chk("tx_busy_n39", {31'd0, tx_busy}, 32'd1);
        bus(32'h0040_0004, 32'h42, 4'b0001, 1'b0);
        chk("tx_fall_busy", {31'd0, tx_busy}, 32'd0);
        chk("tx_fall_txd", {31'd0, txd}, 32'd1);
        frame_q.push_back(8'h42);
        bus(32'h0040_0004, 32'h42, 4'b0001, 1'b0);
        chk("b2b_busy", {31'd0, tx_busy}, 32'd1);
        chk("b2b_txd", {31'd0, txd}, 32'd0);
        idle(45);
        rd(32'h0040_0008, 32'h0);

        bus(32'h0040_0004, 32'h55, 4'b0001, 1'b0);
        idle(15);
        #2;
        resetn = 1'b0;
        #1;
        chk("abort_txd", {31'd0, txd}, 32'd1);
        chk("abort_busy", {31'd0, tx_busy}, 32'd0);
        chk("abort_leds", {28'd0, leds}, 32'd0);
        idle(2);
        @(negedge clk);
        resetn = 1'b1;
        idle(1);
        frame_q.push_back(8'h3C);
        bus(32'h0040_0004, 32'h3C, 4'b0001, 1'b0);
        idle(45);

        rd_q.push_back('{v: 32'h0, chk: 1'b0});
        bus(32'h0040_000C, 32'h0, 4'b0000, 1'b1);
        c1 = io_rdata;
        idle(9);
        rd_q.push_back('{v: 32'h0, chk: 1'b0});
        bus(32'h0040_000C, 32'h0, 4'b0000, 1'b1);
        c2 = io_rdata;
`ifdef IO_CYCLE_COUNTER_EN
        chk("cycles_delta", c2 - c1, 32'd10);
`else
        chk("cycles_rd1", c1, 32'd0);
        chk("cycles_rd2", c2, 32'd0);
`endif

        idle(50);
        chk("frames_left", frame_q.size(), 32'd0);
        chk("reads_left", rd_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
